// File: rtl/branch_ctrl.sv
// branch_ctrl
//   Owns the fetch PC and resolves B / BR in the ID stage against the
//   bypassed N/Z/V flags. It drives the next fetch address and raises a
//   one-cycle IF flush when a branch is taken. It parks the core in HALTED
//   on HLT, and it counts taken branches.
//
// Ports
//   clk, rst    system clock, synchronous active-high reset
//   Flags       bypassed condition codes {N, Z, V}
//   IdValid     ID-stage instruction valid
//   IdOpcode    ID-stage opcode (C = B, D = BR, F = HLT)
//   IdCond      ccc condition field
//   IdImm9      signed word offset for B
//   IdPC        address of the ID-stage instruction
//   RegTarget   forwarded rs value for BR
//   Stall       hazard stall, holds PC and ID
//   PC          current fetch address
//   PCPlus2     PC + 2 (combinational)
//   Taken       ID-stage branch taken this cycle (combinational)
//   Flush       squash IF/ID-bound instruction, equals Taken
//   Halted      core is in HALTED
//   TakenCount  taken-branch count, wraps
//
// state  | meaning
// RUN    | normal fetch, branches and HLT are resolved
// HALTED | PC and counter frozen, left only by rst

module branch_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       Flags,
   input  logic             IdValid,
   input  logic [3:0]       IdOpcode,
   input  logic [2:0]       IdCond,
   input  logic [8:0]       IdImm9,
   input  logic [15:0]      IdPC,
   input  logic [15:0]      RegTarget,
   input  logic             Stall,
   output logic [15:0]      PC,
   output logic [15:0]      PCPlus2,
   output logic             Taken,
   output logic             Flush,
   output logic             Halted,
   output logic [CNT_W-1:0] TakenCount
);

   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

   localparam logic [3:0] OP_B   = 4'hC;
   localparam logic [3:0] OP_BR  = 4'hD;
   localparam logic [3:0] OP_HLT = 4'hF;

   state_t           state_q, state_d;
   logic [15:0]      pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             flag_n, flag_z, flag_v;
   logic             cond_true;
   logic             is_branch;
   logic             advance;
   logic [15:0]      b_offset;
   logic [15:0]      target;

   assign flag_n = Flags[2];
   assign flag_z = Flags[1];
   assign flag_v = Flags[0];

   always_comb begin
      cond_true = 1'b0;
      case (IdCond)
         3'b000:  cond_true = ~flag_z;
         3'b001:  cond_true = flag_z;
         3'b010:  cond_true = ~flag_z & ~flag_n;
         3'b011:  cond_true = flag_n;
         3'b100:  cond_true = flag_z | ~flag_n;
         3'b101:  cond_true = flag_n | flag_z;
         3'b110:  cond_true = flag_v;
         default: cond_true = 1'b1;
      endcase
   end

   assign is_branch = (IdOpcode == OP_B) || (IdOpcode == OP_BR);
   // ID can only act when not stalled and the core is running
   assign advance   = ~rst & ~Stall & (state_q == RUN);

   // word offset: sign-extend and shift left by one
   assign b_offset = {{6{IdImm9[8]}}, IdImm9, 1'b0};
   assign target   = (IdOpcode == OP_BR) ? RegTarget : (IdPC + 16'd2 + b_offset);

   assign Taken      = advance & IdValid & is_branch & cond_true;
   assign Flush      = Taken;
   assign PC         = pc_q;
   assign PCPlus2    = pc_q + 16'd2;
   assign Halted     = (state_q == HALTED);
   assign TakenCount = cnt_q;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      if (advance) begin
         if (IdValid && (IdOpcode == OP_HLT)) begin
            state_d = HALTED;
         end else if (Taken) begin
            pc_d  = target;
            cnt_d = cnt_q + CNT_W'(1);
         end else begin
            pc_d = pc_q + 16'd2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl
//   Directed and random stimulus for branch_ctrl, checked every cycle
//   against a behavioural model of PC, halt state and taken count.

module tb_branch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  Flags;
   logic        IdValid;
   logic [3:0]  IdOpcode;
   logic [2:0]  IdCond;
   logic [8:0]  IdImm9;
   logic [15:0] IdPC;
   logic [15:0] RegTarget;
   logic        Stall;
   logic [15:0] PC;
   logic [15:0] PCPlus2;
   logic        Taken;
   logic        Flush;
   logic        Halted;
   logic [15:0] TakenCount;

   int compared   = 0;
   int mismatched = 0;

   int m_pc;
   bit m_halted;
   int m_cnt;

   branch_ctrl #(.RESET_PC(16'h0000), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .Flags(Flags), .IdValid(IdValid),
      .IdOpcode(IdOpcode), .IdCond(IdCond), .IdImm9(IdImm9), .IdPC(IdPC),
      .RegTarget(RegTarget), .Stall(Stall), .PC(PC), .PCPlus2(PCPlus2),
      .Taken(Taken), .Flush(Flush), .Halted(Halted), .TakenCount(TakenCount)
   );

   always #5 clk = ~clk;

   function automatic bit cond_ref(input logic [2:0] ccc, input logic [2:0] f);
      bit n, z, v;
      n = f[2]; z = f[1]; v = f[0];
      case (ccc)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || (!z && !n);
         3'd5: return n || z;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs are driven just after a negedge; outputs are checked 1 ns later,
   // the model advances across the following posedge.
   task automatic tick();
      bit br, tk;
      int tgt;
      #1;
      br = (IdOpcode == 4'hC) || (IdOpcode == 4'hD);
      tk = !rst && IdValid && !Stall && !m_halted && br && cond_ref(IdCond, Flags);
      chk("Taken", {15'd0, Taken}, {15'd0, tk});
      chk("Flush", {15'd0, Flush}, {15'd0, tk});
      chk("PC", PC, 16'(m_pc));
      chk("PCPlus2", PCPlus2, 16'((m_pc + 2) % 65536));
      chk("Halted", {15'd0, Halted}, {15'd0, m_halted});
      chk("TakenCount", TakenCount, 16'(m_cnt));
      if (IdOpcode == 4'hD) tgt = int'(RegTarget);
      else tgt = (int'(IdPC) + 2 + 2 * int'($signed(IdImm9))) & 32'hFFFF;
      if (rst) begin
         m_pc = 0; m_halted = 0; m_cnt = 0;
      end else if (!m_halted && !Stall) begin
         if (IdValid && IdOpcode == 4'hF) m_halted = 1;
         else if (tk) begin m_pc = tgt; m_cnt = (m_cnt + 1) % 65536; end
         else m_pc = (m_pc + 2) % 65536;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] cc,
                        input logic [2:0] fl, input logic [15:0] ipc,
                        input logic [8:0] imm, input logic [15:0] rt, input logic st);
      IdValid = v; IdOpcode = op; IdCond = cc; Flags = fl;
      IdPC = ipc; IdImm9 = imm; RegTarget = rt; Stall = st;
   endtask

   initial begin
      m_pc = 0; m_halted = 0; m_cnt = 0;
      rst = 1'b1;
      drive(1'b1, 4'hC, 3'b111, 3'b000, 16'h0000, 9'h010, 16'h0000, 1'b0);
      @(negedge clk);
      // reset cycle with a taken-looking branch present: Taken must stay 0
      tick();
      rst = 1'b0;

      // idle cycles: 0000, 0002, ... 0008
      drive(1'b0, 4'h0, 3'b000, 3'b000, 16'h0000, 9'h000, 16'h0000, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      chk("idle_pc", PC, 16'h000A);

      // B EQ with Z=1 from 0010, offset 4 words -> 001A
      drive(1'b1, 4'hC, 3'b001, 3'b010, 16'h0010, 9'h004, 16'h0000, 1'b0);
      tick();
      chk("beq_pc", PC, 16'h001A);
      chk("beq_cnt", TakenCount, 16'd1);

      // GT: N=1 not taken, then N=0 Z=0 taken
      drive(1'b1, 4'hC, 3'b010, 3'b100, 16'h0020, 9'h008, 16'h0000, 1'b0);
      tick();
      chk("bgt_nt_pc", PC, 16'h001C);
      drive(1'b1, 4'hC, 3'b010, 3'b000, 16'h0020, 9'h008, 16'h0000, 1'b0);
      tick();
      chk("bgt_t_pc", PC, 16'h0032);

      // full ccc x flags sweep with B, then a non-branch opcode never taken
      for (int c = 0; c < 8; c++)
         for (int f = 0; f < 8; f++) begin
            drive(1'b1, 4'hC, 3'(c), 3'(f), 16'($urandom), 9'($urandom), 16'h0, 1'b0);
            tick();
         end
      for (int f = 0; f < 8; f++) begin
         drive(1'b1, 4'(f), 3'($urandom), 3'(f), 16'($urandom), 9'($urandom), 16'($urandom), 1'b0);
         tick();
      end

      // BR under stall for 2 cycles, then taken to 1234
      drive(1'b1, 4'hD, 3'b111, 3'b000, 16'h0050, 9'h000, 16'h1234, 1'b1);
      tick();
      tick();
      Stall = 1'b0;
      tick();
      chk("br_pc", PC, 16'h1234);

      // wrap forward and backward B
      drive(1'b1, 4'hC, 3'b111, 3'b000, 16'hFFFC, 9'h001, 16'h0, 1'b0);
      tick();
      chk("wrap_pc", PC, 16'h0000);
      drive(1'b1, 4'hC, 3'b111, 3'b000, 16'h0100, 9'h1FF, 16'h0, 1'b0);
      tick();
      chk("back_pc", PC, 16'h0100);

      // random run without HLT or reset
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom), 4'($urandom_range(0, 14)), 3'($urandom), 3'($urandom),
               16'($urandom), 9'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
         tick();
      end

      // HLT deferred by stall, then halt; branches ignored afterwards
      drive(1'b1, 4'hF, 3'b000, 3'b000, 16'h0040, 9'h000, 16'h0, 1'b1);
      tick();
      Stall = 1'b0;
      tick();
      chk("halted", {15'd0, Halted}, 16'd1);
      drive(1'b1, 4'hC, 3'b111, 3'b000, 16'h0040, 9'h010, 16'h0, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1'b0, 4'h0, 3'b000, 3'b000, 16'h0, 9'h0, 16'h0, 1'b0);
      chk("rst_pc", PC, 16'h0000);
      chk("rst_halted", {15'd0, Halted}, 16'd0);
      chk("rst_cnt", TakenCount, 16'd0);
      tick();

      // random run with HLT and occasional reset
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 19) == 0);
         drive(1'($urandom), 4'($urandom), 3'($urandom), 3'($urandom),
               16'($urandom), 9'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
